// File: rtl/rd_return_buffer.sv
// rd_return_buffer: 144-bit first-word-fall-through return-data buffer for the
// DDR read path, with a credit counter that hands out space one burst at a time.
// Optional feature macro: RB_PARITY_EN adds per-lane even-parity checking at
// push, with the flags stored alongside each word.
//
// Handshake: a word is pushed on any edge where RDvalid=1 and space exists (or a
// pop frees a slot that same edge); a word is popped on any edge where RBen=1 and
// Empty=0; Granted=1 on the edge where Reserve=1 means one burst's credits were
// taken. None of these stall -- rejected requests only set a sticky flag.
module rd_return_buffer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int BURST      = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Reserve,
  output logic                  Granted,
  input  logic [143:0]          RD,
  input  logic                  RDvalid,
  output logic [143:0]          Dout,
  output logic [1:0]            PErr,
  output logic                  Empty,
  input  logic                  RBen,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic [1:0]            ParErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic [143:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, pop, push, drop, granted;
  logic [CW:0]           credit_sum;

  // Push/pop decisions, pointer/count/credit next-state and sticky flags.
  always_comb begin
    empty   = (count_q == '0);
    pop     = RBen && !empty;
    push    = RDvalid && ((count_q != DEPTH_C) || pop);
    drop    = RDvalid && (count_q == DEPTH_C) && !pop;
    granted = Reserve && (credits_q >= BURST_C);

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Pops of unreserved words would push credits past DEPTH; clamp there.
    credit_sum = {1'b0, credits_q} + {{CW{1'b0}}, pop}
               - (granted ? {1'b0, BURST_C} : {(CW+1){1'b0}});
    credits_d  = (credit_sum > {1'b0, DEPTH_C}) ? DEPTH_C : credit_sum[CW-1:0];

    overflow_d  = overflow_q  | drop;
    underflow_d = underflow_q | (RBen && empty);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      credits_q   <= DEPTH_C;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Data storage: no reset needed, contents are only visible while Count > 0.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wptr_q] <= RD;
  end

  assign Granted   = granted;
  assign Empty     = empty;
  assign Count     = count_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign Dout      = mem_q[rptr_q];

`ifdef RB_PARITY_EN
  logic [1:0] flags_q [DEPTH];
  logic [1:0] lane_err;
  logic [1:0] par_err_q, par_err_d;

  // Even parity per byte: check bit i must equal XOR of data byte i.
  function automatic logic lane_bad(input logic [71:0] lane);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) bad = bad | (lane[64+i] ^ (^lane[8*i +: 8]));
    return bad;
  endfunction

  // Per-lane flags of the incoming word and the sticky accumulation.
  always_comb begin
    lane_err  = {lane_bad(RD[143:72]), lane_bad(RD[71:0])};
    par_err_d = par_err_q | (push ? lane_err : 2'b00);
  end

  // Sticky parity error register.
  always_ff @(posedge Clk) begin
    if (Reset) par_err_q <= 2'b00;
    else       par_err_q <= par_err_d;
  end

  // Flag storage travels with the word.
  always_ff @(posedge Clk) begin
    if (push) flags_q[wptr_q] <= lane_err;
  end

  assign PErr   = flags_q[rptr_q];
  assign ParErr = par_err_q;
`else
  assign PErr   = 2'b00;
  assign ParErr = 2'b00;
`endif

endmodule

// File: doc/rd_return_buffer.md
# rd_return_buffer

Single-clock return-data buffer on the memory-to-user read path of the DDR controller. It is the read-side counterpart of the 144-bit write buffer: it accepts 144-bit read words (two 72-bit lanes, 64 data + 8 check bits each) from the memory datapath and presents them to the user in first-word-fall-through order. Because DRAM read data cannot be back-pressured, the controller must reserve buffer space per burst before issuing a read command. A credit counter grants each reservation only when space is guaranteed.

## Interface
- DEPTH_LOG2, 5: log2 of buffer depth in 144-bit words (DEPTH = 2**DEPTH_LOG2).
- BURST, 4: words returned per reserved read burst; 1 ≤ BURST ≤ DEPTH.
- Clk  in  1  sole clock, rising-edge.
- Reset  in  1  synchronous, active-high.
- Reserve  in  1  controller requests space for one BURST.
- Granted  out  1  combinational: Reserve && (Credits ≥ BURST); reservation taken this cycle.
- RD  in  144  read data from memory; lane A = RD[71:0], lane B = RD[143:72], check bits at [71:64] / [143:136].
- RDvalid  in  1  push RD this cycle.
- Dout  out  144  head word; valid only while Empty=0.
- PErr  out  2  per-lane parity error flags for head word (bit0 = lane A).
- Empty  out  1  no word available.
- RBen  in  1  pop head word.
- Count  out  DEPTH_LOG2+1  words stored.
- Overflow  out  1  sticky: a push was dropped.
- Underflow  out  1  sticky: a pop was attempted while Empty.
- ParErr  out  2  sticky OR of PErr over all pushed words.

## Operation
- Storage: DEPTH-entry circular array with write/read pointers of DEPTH_LOG2 bits that wrap modulo DEPTH. Count is tracked separately to distinguish full from empty.
- Push: RDvalid && (Count < DEPTH || pop) writes RD at wptr and increments wptr.
- Dropped push: RDvalid && Count == DEPTH && !pop. RD is discarded, Overflow is set, and state is otherwise unchanged.
- Pop: pop = RBen && !Empty. A pop increments rptr.
- Pop on empty: RBen while Empty has no state effect except setting Underflow.
- Count update: Count += push − pop. Push and pop in the same cycle leaves Count unchanged, including at Count = DEPTH and Count = 0. At Count = 0, a simultaneous RBen is not a pop: the word is pushed and Underflow is set.
- Credits register (DEPTH_LOG2+1 bits, reset to DEPTH): Credits += pop − (Granted ? BURST : 0). All terms apply in the same cycle. Credits never exceeds DEPTH and never goes negative.
- Credits are not consumed by pushes. Data arriving without a reservation is accepted only if physical space exists.
- Empty = (Count == 0). Dout and PErr are read combinationally from the entry at rptr.
- Reset mid-operation discards all stored words and outstanding reservations. Any RD arriving after reset for a pre-reset reservation is treated as unreserved.

## Timing
- Reset values: Empty=1, Count=0, Credits=DEPTH, Overflow=0, Underflow=0, ParErr=0, pointers=0. Granted follows Reserve and Credits combinationally. Dout and PErr are undefined while Empty.
- Push-to-visible latency: a push at edge N gives Empty=0 and valid Dout from edge N onward, i.e. one cycle after RDvalid is sampled.
- Pop: Dout shows the next word after the popping edge. Back-to-back pops every cycle are supported.
- Reservation: Granted is valid in the same cycle as Reserve. The decrement takes effect at that edge. One grant at most per cycle.
- Throughput: 1 push + 1 pop per cycle sustained.

## Configuration
- RB_PARITY_EN defined:
  - At push, each lane computes 8 even-parity checks: check bit i must equal XOR of data byte i.
  - A mismatch in any byte sets that lane's flag. Flags are stored with the word (2 extra bits per entry) and presented on PErr with it.
  - ParErr ORs in the flags of every accepted push.
- RB_PARITY_EN undefined: no parity logic or flag storage; PErr and ParErr are tied to 0.

## Test plan
- Reset; hold Reserve for 9 cycles with no pops → Granted=1 for cycles 1–8 (Credits 32→0), Granted=0 on cycle 9.
- Push 4 words 0x…01 to 0x…04 on consecutive cycles → Empty=0 one cycle after the first RDvalid; four RBen pops return 01, 02, 03, 04 in order; Empty=1 and Count=0 afterwards.
- Fill to Count=32, then RDvalid and RBen in the same cycle → Count stays 32, Overflow=0, the oldest word leaves and the new word enters last.
- At Count=32, RDvalid with RBen=0 → word dropped, Overflow=1, Count=32, contents unchanged.
- RBen with Empty=1 → Underflow=1, Count=0, Credits unchanged. Reserve granted concurrently with a pop at Credits=4 → Credits becomes 1.
- With RB_PARITY_EN defined, push a word whose lane-B byte 3 has one data bit flipped → PErr=2'b10 when the word reaches the head; ParErr=2'b10 remains set after the pop until Reset.
